pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline; drives the write enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sequences data-memory handshakes for the instruction in MEM, resolves load-use hazards and branch flushes, and maintains a sticky memory-timeout error and a saturating stall-cycle counter.

## Interface
- TIMEOUT, 64, max WAIT cycles before error; legal range 1..255
- STALL_CNT_W, 16, width of stall counter
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- id_rs_addr  in  3  source register A of instruction in ID
- id_rt_addr  in  3  source register B of instruction in ID
- id_rs_used  in  1  ID reads rs
- id_rt_used  in  1  ID reads rt
- ex_load  in  1  instruction in EX is a load
- ex_rdest_addr  in  3  destination register of instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_op  in  1  instruction in MEM accesses memory (load or store)
- mem_ack  in  1  data memory completes the current access this cycle
- mem_req  out  1  access request to data memory
- PC_Wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen  out  1 each  register write enables
- IFtoID_flush, IDtoEX_flush  out  1 each  load NOP bubble instead of input on this write
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  STALL_CNT_W  cycles with PC_Wen=0, saturating

## Operation
- FSM states: RUN, WAIT, ERR. Reset state RUN.
- RUN, mem_op=0 or mem_ack=1: no memory stall. mem_op=1 with mem_ack=0: freeze, next state WAIT, wait counter cleared to 1.
- WAIT: freeze. mem_ack=1 → release this cycle, next state RUN. Else counter increments; when counter == TIMEOUT and mem_ack=0 → ERR.
- ERR: freeze permanently, mem_req=0, mem_err=1; exit only by reset.
- mem_req = mem_op in RUN; 1 in WAIT; 0 in ERR. Request held level until ack.
- Freeze: all five Wens=0, both flushes=0.
- Priority when not frozen: branch > load-use > normal.
- Branch (ex_branch_taken=1): all Wens=1, IFtoID_flush=1, IDtoEX_flush=1.
- Load-use: ex_load=1 and ((id_rs_used and id_rs_addr==ex_rdest_addr) or (id_rt_used and id_rt_addr==ex_rdest_addr)). Register 0 is an ordinary register, no exclusion. Response: PC_Wen=0, IFtoID_Wen=0, IDtoEX_Wen=1 with IDtoEX_flush=1, EXtoMEM_Wen=MEMtoWB_Wen=1.
- Normal: all Wens=1, flushes=0.
- stall_cnt increments each cycle PC_Wen=0 (freeze or load-use), holds at all-ones.

## Timing
- All outputs combinational from current state and inputs; state, wait counter, mem_err, stall_cnt registered on posedge clk.
- While resetn=0: state RUN, wait counter 0, mem_err 0, stall_cnt 0; all Wens, flushes and mem_req forced 0.
- Reset asserted mid-WAIT: access abandoned, mem_req drops immediately.
- Zero-wait memory (ack same cycle as mem_op in RUN): no stall, no stall_cnt increment.
- N-cycle memory (ack on cycle N after req rises): N freeze cycles, stall_cnt += N.
- Ack on the cycle counter == TIMEOUT: release, not error.
- Branch or load-use coincident with a memory freeze: suppressed during freeze, applied on release cycle if inputs still assert.
- mem_ack in RUN with mem_op=0 or in ERR: ignored.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, WAIT, ERR), REG_ADDR_W=3, wait-counter width 8.
- Sub-module hazard_detect: purely combinational load-use comparator producing one bit; FSM, counters and output muxing stay in top.

## Test plan
- Normal flow: no hazards, mem_op=0 for 10 cycles → all Wens 1, flushes 0, stall_cnt 0.
- Load-use: ex_load=1, ex_rdest_addr=3, id_rt_addr=3, id_rt_used=1 → PC_Wen=IFtoID_Wen=0, IDtoEX_flush=1, stall_cnt=1; same with id_rt_used=0 → no stall.
- Memory wait: mem_op=1, mem_ack on 3rd cycle → freeze 3 cycles, mem_req high 3 cycles, stall_cnt=3, state returns to RUN.
- Timeout: TIMEOUT=4, mem_op=1, no ack → ERR after 4 WAIT cycles, mem_err=1, mem_req=0, Wens 0 until resetn pulsed low.
- Simultaneous: branch taken and load-use together → flushes 1, all Wens 1; branch during memory freeze → flushes 0 until ack cycle.
- Saturation: STALL_CNT_W=4, 20 load-use cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load in EX
// has not produced yet. Register 0 is an ordinary register here.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rdest_addr,
  output logic                  load_use
);

  assign load_use = ex_load &
                    ((id_rs_used & (id_rs_addr == ex_rdest_addr)) |
                     (id_rt_used & (id_rt_addr == ex_rdest_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory-wait FSM with timeout, branch flush,
// load-use bubble insertion and a saturating count of PC-stalled cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [REG_ADDR_W-1:0]  id_rs_addr,
  input  logic [REG_ADDR_W-1:0]  id_rt_addr,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   ex_load,
  input  logic [REG_ADDR_W-1:0]  ex_rdest_addr,
  input  logic                   ex_branch_taken,
  input  logic                   mem_op,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   PC_Wen,
  output logic                   IFtoID_Wen,
  output logic                   IDtoEX_Wen,
  output logic                   EXtoMEM_Wen,
  output logic                   MEMtoWB_Wen,
  output logic                   IFtoID_flush,
  output logic                   IDtoEX_flush,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_CNT_W-1:0] TO = WAIT_CNT_W'(TIMEOUT);

  ctrl_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wcnt_q, wcnt_d;
  logic                   mem_err_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   freeze, req, load_use;

  hazard_detect u_hazard (
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .ex_load       (ex_load),
    .ex_rdest_addr (ex_rdest_addr),
    .load_use      (load_use)
  );

  // The ack cycle itself is not frozen: the load data is captured on that edge.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b0;
    req     = 1'b0;
    case (state_q)
      RUN: begin
        req = mem_op;
        if (mem_op && !mem_ack) begin
          freeze  = 1'b1;
          state_d = WAIT;
          wcnt_d  = WAIT_CNT_W'(1);
        end
      end
      WAIT: begin
        req = 1'b1;
        if (mem_ack) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          freeze = 1'b1;
          if (wcnt_q == TO) state_d = ERR;
          else              wcnt_d  = wcnt_q + 1'b1;
        end
      end
      ERR: freeze = 1'b1;
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Outputs are gated by resetn so reset drops them without waiting for a clock.
  always_comb begin
    PC_Wen       = 1'b0;
    IFtoID_Wen   = 1'b0;
    IDtoEX_Wen   = 1'b0;
    EXtoMEM_Wen  = 1'b0;
    MEMtoWB_Wen  = 1'b0;
    IFtoID_flush = 1'b0;
    IDtoEX_flush = 1'b0;
    mem_req      = resetn & req;
    if (resetn && !freeze) begin
      IDtoEX_Wen  = 1'b1;
      EXtoMEM_Wen = 1'b1;
      MEMtoWB_Wen = 1'b1;
      if (ex_branch_taken) begin
        PC_Wen       = 1'b1;
        IFtoID_Wen   = 1'b1;
        IFtoID_flush = 1'b1;
        IDtoEX_flush = 1'b1;
      end else if (load_use) begin
        IDtoEX_flush = 1'b1;
      end else begin
        PC_Wen     = 1'b1;
        IFtoID_Wen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_d == ERR) mem_err_q <= 1'b1;
      if (!PC_Wen && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: single-cycle vector table for the combinational priority logic,
// plus hand sequences for memory wait, timeout, reset abort and counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT     = 4;
  localparam int STALL_CNT_W = 4;

  logic       clk, resetn;
  logic [2:0] id_rs_addr, id_rt_addr, ex_rdest_addr;
  logic       id_rs_used, id_rt_used, ex_load, ex_branch_taken, mem_op, mem_ack;
  logic       mem_req, PC_Wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen;
  logic       IFtoID_flush, IDtoEX_flush, mem_err;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic [4:0] wens;
  logic [1:0] fls;
  assign wens = {PC_Wen, IFtoID_Wen, IDtoEX_Wen, EXtoMEM_Wen, MEMtoWB_Wen};
  assign fls  = {IFtoID_flush, IDtoEX_flush};

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_load(ex_load), .ex_rdest_addr(ex_rdest_addr),
    .ex_branch_taken(ex_branch_taken), .mem_op(mem_op), .mem_ack(mem_ack),
    .mem_req(mem_req), .PC_Wen(PC_Wen), .IFtoID_Wen(IFtoID_Wen),
    .IDtoEX_Wen(IDtoEX_Wen), .EXtoMEM_Wen(EXtoMEM_Wen), .MEMtoWB_Wen(MEMtoWB_Wen),
    .IFtoID_flush(IFtoID_flush), .IDtoEX_flush(IDtoEX_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rs, rt;
    logic       rsu, rtu, ld;
    logic [2:0] rd;
    logic       br, mo, ma;
    logic [4:0] wen;
    logic [1:0] fl;
    logic       req;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_addr = 3'd0; id_rt_addr = 3'd0; ex_rdest_addr = 3'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_load = 1'b0;
    ex_branch_taken = 1'b0; mem_op = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
  endtask

  task automatic set_load_use();
    ex_load = 1'b1; ex_rdest_addr = 3'd3; id_rt_addr = 3'd3; id_rt_used = 1'b1;
  endtask

  initial begin
    //        rs    rt    rsu   rtu   ld    rd    br    mo    ma    wen        fl     req
    tbl[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 1'b0};
    tbl[1]  = '{3'd1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'b00111, 2'b01, 1'b0};
    tbl[2]  = '{3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 1'b0};
    tbl[3]  = '{3'd5, 3'd1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 5'b00111, 2'b01, 1'b0};
    tbl[4]  = '{3'd5, 3'd1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 1'b0};
    tbl[5]  = '{3'd0, 3'd6, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 2'b01, 1'b0};
    tbl[6]  = '{3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 1'b0};
    tbl[7]  = '{3'd1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b11, 1'b0};
    tbl[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b11, 1'b0};
    tbl[9]  = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b00, 1'b1};
    tbl[10] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 2'b00, 1'b0};
    tbl[11] = '{3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 5'b00111, 2'b01, 1'b1};

    // Reset state: outputs forced low even with active-looking inputs.
    idle_inputs();
    resetn = 1'b0;
    mem_op = 1'b1; ex_branch_taken = 1'b1;
    #2;
    chk("rst_wens", 32'(wens), 32'h0);
    chk("rst_flush", 32'(fls), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    do_reset();

    // Normal flow for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk("normal_wens", 32'(wens), 32'h1f);
      chk("normal_flush", 32'(fls), 32'h0);
      step();
    end
    chk("normal_cnt", 32'(stall_cnt), 32'h0);

    // Single-cycle vectors, all staying in RUN.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      id_rs_addr = tbl[i].rs; id_rt_addr = tbl[i].rt;
      id_rs_used = tbl[i].rsu; id_rt_used = tbl[i].rtu;
      ex_load = tbl[i].ld; ex_rdest_addr = tbl[i].rd;
      ex_branch_taken = tbl[i].br; mem_op = tbl[i].mo; mem_ack = tbl[i].ma;
      #1;
      chk($sformatf("vec%0d_wens", i), 32'(wens), 32'(tbl[i].wen));
      chk($sformatf("vec%0d_flush", i), 32'(fls), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(tbl[i].req));
      step();
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), tbl[i].wen[4] ? 32'h0 : 32'h1);
    end

    // Memory wait: ack arrives 3 cycles after the request rises; branch held throughout.
    do_reset();
    mem_op = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_frz_wens", 32'(wens), 32'h0);
      chk("wait_frz_flush", 32'(fls), 32'h0);
      chk("wait_frz_req", 32'(mem_req), 32'h1);
      step();
    end
    mem_ack = 1'b1;
    #1;
    chk("wait_ack_wens", 32'(wens), 32'h1f);
    chk("wait_ack_flush", 32'(fls), 32'h3);
    chk("wait_ack_req", 32'(mem_req), 32'h1);
    step();
    idle_inputs();
    #1;
    chk("wait_after_req", 32'(mem_req), 32'h0);
    chk("wait_after_wens", 32'(wens), 32'h1f);
    chk("wait_cnt", 32'(stall_cnt), 32'h3);

    // Ack exactly on the cycle the wait counter reaches TIMEOUT: release, no error.
    do_reset();
    mem_op = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) step();
    mem_ack = 1'b1;
    #1;
    chk("edge_ack_wens", 32'(wens), 32'h1f);
    step();
    idle_inputs();
    #1;
    chk("edge_ack_err", 32'(mem_err), 32'h0);
    chk("edge_ack_wens2", 32'(wens), 32'h1f);
    chk("edge_ack_cnt", 32'(stall_cnt), 32'(TIMEOUT));

    // Timeout: no ack ever; ERR after TIMEOUT WAIT cycles.
    do_reset();
    mem_op = 1'b1;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      #1;
      chk("to_pre_req", 32'(mem_req), 32'h1);
      chk("to_pre_err", 32'(mem_err), 32'h0);
      chk("to_pre_wens", 32'(wens), 32'h0);
      step();
    end
    #1;
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_req", 32'(mem_req), 32'h0);
    chk("to_wens", 32'(wens), 32'h0);
    mem_ack = 1'b1; ex_branch_taken = 1'b1;
    step(); step();
    chk("to_err_hold", 32'(mem_err), 32'h1);
    chk("to_wens_hold", 32'(wens), 32'h0);
    chk("to_flush_hold", 32'(fls), 32'h0);
    chk("to_req_hold", 32'(mem_req), 32'h0);
    do_reset();
    #1;
    chk("to_clr_err", 32'(mem_err), 32'h0);
    chk("to_clr_wens", 32'(wens), 32'h1f);

    // Reset asserted mid-WAIT drops the request without a clock edge.
    mem_op = 1'b1;
    step(); step();
    #1;
    chk("abort_req_before", 32'(mem_req), 32'h1);
    resetn = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_cnt", 32'(stall_cnt), 32'h0);
    step();
    resetn = 1'b1;
    mem_op = 1'b0;
    #1;
    chk("abort_wens", 32'(wens), 32'h1f);

    // Saturation: 20 load-use cycles on a 4-bit counter.
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(stall_cnt), 32'hf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
